// File: rtl/nes_cpu_bus_target.sv
// 6502 CPU-bus responder: RAM/PPU/PRG decode, open-bus latch, cycle parity and $4014 OAM DMA.
// Optional joypad shift registers at $4016/$4017 when NES_JOYPAD_EN is defined.
module nes_cpu_bus_target #(
    parameter int RAM_ADDR_BITS = 11,
    parameter int PRG_ADDR_BITS = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              cpu_addr,
    input  logic                     cpu_write,
    input  logic [7:0]               cpu_d_out,
    output logic [7:0]               cpu_d_in,
    output logic                     cpu_ready,
    output logic                     ppu_cs,
    output logic                     ppu_we,
    output logic [2:0]               ppu_reg,
    output logic [7:0]               ppu_wdata,
    input  logic [7:0]               ppu_rdata,
    output logic [PRG_ADDR_BITS-1:0] prg_addr,
    input  logic [7:0]               prg_rdata,
    input  logic [7:0]               pad1,
    input  logic [7:0]               pad2
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, RD, WR} state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  dma_idx_q, dma_idx_d;
    logic [7:0]  dma_buf_q, dma_buf_d;
    logic [7:0]  open_bus_q, open_bus_d;
    logic        dma_pending_q, dma_pending_d;
    logic        cyc_odd_q, cyc_odd_d;
    logic [7:0]  ram_q [2**RAM_ADDR_BITS];

    logic [15:0] bus_addr;
    logic        sel_ram, sel_ppu, sel_prg, sel_dma_reg;
    logic        cpu_wr, rd_cyc, ram_we;
    logic [7:0]  rdata;

    // The DMA engine owns the bus only while it is moving bytes.
    assign bus_addr    = (state_q == RD || state_q == WR) ? {page_q, dma_idx_q} : cpu_addr;
    assign sel_ram     = (bus_addr[15:13] == 3'b000);
    assign sel_ppu     = (bus_addr[15:13] == 3'b001);
    assign sel_prg     = bus_addr[15];
    assign sel_dma_reg = (bus_addr == 16'h4014);
    assign cpu_wr      = cpu_write && (state_q == IDLE);
    assign rd_cyc      = ((state_q == IDLE) && !cpu_write) || (state_q == RD);
    assign ram_we      = cpu_wr && sel_ram;
    assign prg_addr    = bus_addr[PRG_ADDR_BITS-1:0];
    assign cpu_ready   = (state_q == IDLE);
    assign cpu_d_in    = rdata;

`ifdef NES_JOYPAD_EN
    logic       strobe_q, strobe_d;
    logic [7:0] sh1_q, sh1_d, sh2_q, sh2_d;
    logic       sel_joy1, sel_joy2;

    assign sel_joy1 = (bus_addr == 16'h4016);
    assign sel_joy2 = (bus_addr == 16'h4017);

    always_comb begin
        strobe_d = strobe_q;
        sh1_d    = sh1_q;
        sh2_d    = sh2_q;
        if (cpu_wr && sel_joy1) strobe_d = cpu_d_out[0];
        if (strobe_q) begin
            sh1_d = pad1;
            sh2_d = pad2;
        end else if ((state_q == IDLE) && !cpu_write) begin
            // Serial shift fills with 1s so reads past the eighth return 1.
            if (sel_joy1) sh1_d = {1'b1, sh1_q[7:1]};
            if (sel_joy2) sh2_d = {1'b1, sh2_q[7:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_q <= 1'b0;
            sh1_q    <= 8'h00;
            sh2_q    <= 8'h00;
        end else begin
            strobe_q <= strobe_d;
            sh1_q    <= sh1_d;
            sh2_q    <= sh2_d;
        end
    end
`else
    logic unused_pads;
    assign unused_pads = ^{pad1, pad2};
`endif

    always_comb begin
        rdata = open_bus_q;
        if (sel_ram)      rdata = ram_q[bus_addr[RAM_ADDR_BITS-1:0]];
        else if (sel_ppu) rdata = ppu_rdata;
        else if (sel_prg) rdata = prg_rdata;
`ifdef NES_JOYPAD_EN
        else if (sel_joy1) rdata = {open_bus_q[7:1], sh1_q[0]};
        else if (sel_joy2) rdata = {open_bus_q[7:1], sh2_q[0]};
`endif
    end

    always_comb begin
        ppu_cs    = 1'b0;
        ppu_we    = 1'b0;
        ppu_reg   = bus_addr[2:0];
        ppu_wdata = cpu_d_out;
        if (state_q == WR) begin
            ppu_cs    = 1'b1;
            ppu_we    = 1'b1;
            ppu_reg   = 3'd4;
            ppu_wdata = dma_buf_q;
        end else if (state_q == IDLE || state_q == RD) begin
            ppu_cs = sel_ppu;
            ppu_we = sel_ppu && cpu_wr;
        end
    end

    always_comb begin
        state_d       = state_q;
        page_d        = page_q;
        dma_idx_d     = dma_idx_q;
        dma_buf_d     = dma_buf_q;
        dma_pending_d = dma_pending_q;
        cyc_odd_d     = ~cyc_odd_q;
        open_bus_d    = open_bus_q;
        if (cpu_wr)      open_bus_d = cpu_d_out;
        else if (rd_cyc) open_bus_d = rdata;
        case (state_q)
            IDLE: begin
                if (cpu_wr && sel_dma_reg) begin
                    page_d        = cpu_d_out;
                    dma_pending_d = 1'b1;
                end
                // Never halt on a write cycle; the request waits for a read.
                if (dma_pending_q && !cpu_write) state_d = HALT;
            end
            HALT:  state_d = cyc_odd_q ? ALIGN : RD;
            ALIGN: state_d = RD;
            RD: begin
                dma_buf_d = rdata;
                state_d   = WR;
            end
            WR: begin
                if (dma_idx_q == 8'hFF) begin
                    state_d       = IDLE;
                    dma_pending_d = 1'b0;
                    dma_idx_d     = 8'h00;
                end else begin
                    dma_idx_d = dma_idx_q + 8'd1;
                    state_d   = RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            page_q        <= 8'h00;
            dma_idx_q     <= 8'h00;
            dma_buf_q     <= 8'h00;
            dma_pending_q <= 1'b0;
            cyc_odd_q     <= 1'b0;
            open_bus_q    <= 8'h00;
        end else begin
            state_q       <= state_d;
            page_q        <= page_d;
            dma_idx_q     <= dma_idx_d;
            dma_buf_q     <= dma_buf_d;
            dma_pending_q <= dma_pending_d;
            cyc_odd_q     <= cyc_odd_d;
            open_bus_q    <= open_bus_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[bus_addr[RAM_ADDR_BITS-1:0]] <= cpu_d_out;
    end
endmodule

// File: tb/tb_nes_cpu_bus_target.sv
// Directed bench for nes_cpu_bus_target: vector table for decode/open bus, hand sequences for DMA, deferral, reset and joypad.
module tb_nes_cpu_bus_target;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h5000;
    logic        cpu_write = 1'b0;
    logic [7:0]  cpu_d_out = 8'h00;
    logic [7:0]  cpu_d_in;
    logic        cpu_ready;
    logic        ppu_cs, ppu_we;
    logic [2:0]  ppu_reg;
    logic [7:0]  ppu_wdata;
    logic [7:0]  ppu_rdata = 8'h00;
    logic [14:0] prg_addr;
    logic [7:0]  prg_rdata = 8'h00;
    logic [7:0]  pad1 = 8'h00, pad2 = 8'h00;

    int checks = 0;
    int errors = 0;
    int tb_cyc;

    nes_cpu_bus_target #(.RAM_ADDR_BITS(11), .PRG_ADDR_BITS(15)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_write(cpu_write),
        .cpu_d_out(cpu_d_out), .cpu_d_in(cpu_d_in), .cpu_ready(cpu_ready),
        .ppu_cs(ppu_cs), .ppu_we(ppu_we), .ppu_reg(ppu_reg), .ppu_wdata(ppu_wdata),
        .ppu_rdata(ppu_rdata), .prg_addr(prg_addr), .prg_rdata(prg_rdata),
        .pad1(pad1), .pad2(pad2)
    );

    always #5 clk = ~clk;

    // Cycle count since reset release; its LSB is the expected CPU cycle parity.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic [7:0]  ppu_rd;
        logic [7:0]  prg_rd;
        logic        chk_din;
        logic [7:0]  exp_din;
        logic        exp_cs;
        logic        exp_we;
        logic [2:0]  exp_reg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic [15:0] a, logic [7:0] d, logic [7:0] prd,
                                logic [7:0] grd, logic cd, logic [7:0] din,
                                logic cs, logic we, logic [2:0] rg);
        vec_t v;
        v.wr = wr; v.addr = a; v.dout = d; v.ppu_rd = prd; v.prg_rd = grd;
        v.chk_din = cd; v.exp_din = din; v.exp_cs = cs; v.exp_we = we; v.exp_reg = rg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [15:0] a, input logic [7:0] d);
        cpu_write = wr;
        cpu_addr  = a;
        cpu_d_out = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_cycle(input logic wr, input logic [15:0] a, input logic [7:0] d);
        drive(wr, a, d);
        tick();
    endtask

    // Full DMA of a page whose bytes equal their index; HALT parity forced to want_odd.
    task automatic run_dma(input logic [7:0] page, input logic want_odd, input logic disturb);
        int stall;
        int nb;
        int halt_par;
        bit done;
        stall = 0; nb = 0; halt_par = -1; done = 0;
        if (tb_cyc[0] != want_odd) bus_cycle(1'b0, 16'h5000, 8'h00);
        bus_cycle(1'b1, 16'h4014, page);
        drive(1'b0, 16'h5000, 8'h00);
        for (int c = 0; c < 1200 && !done; c++) begin
            @(negedge clk);
            if (!cpu_ready) begin
                if (stall == 0) halt_par = tb_cyc & 1;
                stall++;
            end else if (stall > 0) begin
                done = 1;
            end
            if (ppu_cs && ppu_we) begin
                chk("dma_reg", {29'd0, ppu_reg}, 32'd4);
                chk("dma_data", {24'd0, ppu_wdata}, nb & 32'hFF);
                nb++;
            end
            if (disturb && stall >= 1 && stall <= 5)       drive(1'b1, 16'h0201, 8'hEE);
            else if (disturb && stall >= 6 && stall <= 10) drive(1'b1, 16'h4014, 8'h03);
            else                                           drive(1'b0, 16'h5000, 8'h00);
            if (!done) tick();
        end
        chk("dma_done", {31'd0, done}, 32'd1);
        chk("dma_halt_parity", halt_par, {31'd0, want_odd});
        chk("dma_stall_len", stall, want_odd ? 514 : 513);
        chk("dma_byte_count", nb, 256);
        tick();
    endtask

    initial begin
        int nb;
        bit hit;
        #1;
        chk("rst_ready", {31'd0, cpu_ready}, 1);
        chk("rst_ppu_cs", {31'd0, ppu_cs}, 0);
        chk("rst_ppu_we", {31'd0, ppu_we}, 0);
        chk("rst_open_bus", {24'd0, cpu_d_in}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        vecs.push_back(mk(0, 16'h5000, 8'h00, 8'h00, 8'h00, 1, 8'h00, 0, 0, 3'd0));
        vecs.push_back(mk(1, 16'h0005, 8'hA5, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'd0));
        vecs.push_back(mk(0, 16'h0805, 8'h00, 8'h00, 8'h00, 1, 8'hA5, 0, 0, 3'd0));
        vecs.push_back(mk(0, 16'h1805, 8'h00, 8'h00, 8'h00, 1, 8'hA5, 0, 0, 3'd0));
        vecs.push_back(mk(0, 16'h5000, 8'h00, 8'h00, 8'h00, 1, 8'hA5, 0, 0, 3'd0));
        vecs.push_back(mk(0, 16'h3FFA, 8'h00, 8'h3C, 8'h00, 1, 8'h3C, 1, 0, 3'd2));
        vecs.push_back(mk(0, 16'h5000, 8'h00, 8'h3C, 8'h00, 1, 8'h3C, 0, 0, 3'd0));
        vecs.push_back(mk(0, 16'h8123, 8'h00, 8'h00, 8'h4C, 1, 8'h4C, 0, 0, 3'd0));
        vecs.push_back(mk(0, 16'h5000, 8'h00, 8'h00, 8'h00, 1, 8'h4C, 0, 0, 3'd0));
        vecs.push_back(mk(0, 16'h4014, 8'h00, 8'h00, 8'h00, 1, 8'h4C, 0, 0, 3'd0));
        vecs.push_back(mk(1, 16'h2007, 8'h5A, 8'h00, 8'h00, 0, 8'h00, 1, 1, 3'd7));
        vecs.push_back(mk(0, 16'h5000, 8'h00, 8'h00, 8'h00, 1, 8'h5A, 0, 0, 3'd0));
        vecs.push_back(mk(1, 16'h1FFF, 8'h44, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'd0));
        vecs.push_back(mk(0, 16'h07FF, 8'h00, 8'h00, 8'h00, 1, 8'h44, 0, 0, 3'd0));
        vecs.push_back(mk(1, 16'h6000, 8'h77, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'd0));
        vecs.push_back(mk(0, 16'h6000, 8'h00, 8'h00, 8'h00, 1, 8'h77, 0, 0, 3'd0));
        vecs.push_back(mk(1, 16'h8000, 8'h11, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'd0));
        vecs.push_back(mk(0, 16'h8000, 8'h00, 8'h00, 8'h22, 1, 8'h22, 0, 0, 3'd0));
        vecs.push_back(mk(0, 16'h2000, 8'h00, 8'h99, 8'h00, 1, 8'h99, 1, 0, 3'd0));
`ifndef NES_JOYPAD_EN
        vecs.push_back(mk(0, 16'h4016, 8'h00, 8'h00, 8'h00, 1, 8'h99, 0, 0, 3'd0));
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].addr, vecs[i].dout);
            ppu_rdata = vecs[i].ppu_rd;
            prg_rdata = vecs[i].prg_rd;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), {31'd0, cpu_ready}, 1);
            if (vecs[i].chk_din) chk($sformatf("vec%0d_d_in", i), {24'd0, cpu_d_in}, {24'd0, vecs[i].exp_din});
            chk($sformatf("vec%0d_ppu_cs", i), {31'd0, ppu_cs}, {31'd0, vecs[i].exp_cs});
            chk($sformatf("vec%0d_ppu_we", i), {31'd0, ppu_we}, {31'd0, vecs[i].exp_we});
            if (vecs[i].exp_cs) chk($sformatf("vec%0d_ppu_reg", i), {29'd0, ppu_reg}, {29'd0, vecs[i].exp_reg});
            if (vecs[i].exp_we) chk($sformatf("vec%0d_ppu_wdata", i), {24'd0, ppu_wdata}, {24'd0, vecs[i].dout});
            tick();
        end

        drive(1'b0, 16'hC123, 8'h00);
        @(negedge clk);
        chk("prg_addr_mask", {17'd0, prg_addr}, 32'h4123);
        tick();

        // Source page $02 holds bytes equal to their index.
        for (int i = 0; i < 256; i++) bus_cycle(1'b1, 16'h0200 + 16'(i), 8'(i));

        run_dma(8'h02, 1'b0, 1'b1);
        drive(1'b0, 16'h0201, 8'h00);
        @(negedge clk);
        chk("dma_cpu_write_ignored", {24'd0, cpu_d_in}, 32'h01);
        tick();
        hit = 0;
        for (int c = 0; c < 20; c++) begin
            bus_cycle(1'b0, 16'h5000, 8'h00);
            if (!cpu_ready) hit = 1;
        end
        chk("no_second_dma", {31'd0, hit}, 0);

        run_dma(8'h02, 1'b1, 1'b0);

        // Deferral across two back-to-back writes.
        drive(1'b1, 16'h4014, 8'h02);
        @(negedge clk); chk("defer_ready_w0", {31'd0, cpu_ready}, 1); tick();
        drive(1'b1, 16'h0300, 8'h11);
        @(negedge clk); chk("defer_ready_w1", {31'd0, cpu_ready}, 1); tick();
        drive(1'b1, 16'h0301, 8'h22);
        @(negedge clk); chk("defer_ready_w2", {31'd0, cpu_ready}, 1); tick();
        drive(1'b0, 16'h0300, 8'h00);
        @(negedge clk);
        chk("defer_ready_rd", {31'd0, cpu_ready}, 1);
        chk("defer_rd_data", {24'd0, cpu_d_in}, 32'h11);
        tick();
        drive(1'b0, 16'h5000, 8'h00);
        @(negedge clk);
        chk("defer_halt", {31'd0, cpu_ready}, 0);
        hit = 0;
        for (int c = 0; c < 600 && !hit; c++) begin
            tick();
            @(negedge clk);
            if (cpu_ready) hit = 1;
        end
        chk("defer_dma_end", {31'd0, hit}, 1);
        tick();
        drive(1'b0, 16'h0301, 8'h00);
        @(negedge clk); chk("defer_w2_kept", {24'd0, cpu_d_in}, 32'h22); tick();

        // Reset at the 100th DMA byte.
        bus_cycle(1'b1, 16'h4014, 8'h02);
        drive(1'b0, 16'h5000, 8'h00);
        nb = 0; hit = 0;
        for (int c = 0; c < 600 && !hit; c++) begin
            @(negedge clk);
            if (ppu_cs && ppu_we) nb++;
            if (nb == 100) hit = 1;
            else tick();
        end
        chk("rst_dma_reached", {31'd0, hit}, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_ready", {31'd0, cpu_ready}, 1);
        chk("rst_mid_ppu_cs", {31'd0, ppu_cs}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        hit = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!cpu_ready || ppu_cs) hit = 1;
            tick();
        end
        chk("rst_mid_quiet", {31'd0, hit}, 0);
        run_dma(8'h02, 1'b0, 1'b0);

`ifdef NES_JOYPAD_EN
        pad1 = 8'h81;
        bus_cycle(1'b1, 16'h4016, 8'h01);
        bus_cycle(1'b1, 16'h4016, 8'h00);
        begin
            logic [8:0] exp_bits;
            exp_bits = 9'b110000001;
            for (int k = 0; k < 9; k++) begin
                drive(1'b0, 16'h4016, 8'h00);
                @(negedge clk);
                chk($sformatf("joy_read%0d", k), {31'd0, cpu_d_in[0]}, {31'd0, exp_bits[k]});
                tick();
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
